// File: rtl/diffeq_datapath_if.sv
// Controller-to-datapath bundle for the Euler differential-equation solver.
// The controller (master) drives phase code, load strobes and operand word.
interface diffeq_datapath_if #(
  parameter int WIDTH = 16
);

  logic [2:0]       state;
  logic             load_x;
  logic             load_dx;
  logic             load_u;
  logic             load_a;
  logic [WIDTH-1:0] data_in;
  logic             compute_done;
  logic             continue_while;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] u_out;

  modport master (
    output state,
    output load_x,
    output load_dx,
    output load_u,
    output load_a,
    output data_in,
    input  compute_done,
    input  continue_while,
    input  x_out,
    input  y_out,
    input  u_out
  );

  modport slave (
    input  state,
    input  load_x,
    input  load_dx,
    input  load_u,
    input  load_a,
    input  data_in,
    output compute_done,
    output continue_while,
    output x_out,
    output y_out,
    output u_out
  );

endinterface

// File: rtl/diffeq_datapath.sv
// Datapath for one Euler step of y'' + 3xy' + 3y = 0, sequenced by phase codes
// from an external controller; each compute phase lasts three cycles.
module diffeq_datapath #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         reset,
  diffeq_datapath_if.slave bus
);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'b000,
    PH_READ   = 3'b001,
    PH_C1     = 3'b010,
    PH_C2     = 3'b011,
    PH_C3     = 3'b100,
    PH_C4     = 3'b101,
    PH_DONE   = 3'b110,
    PH_UNUSED = 3'b111
  } phase_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_CYC1 = 2'd1,
    SEQ_CYC2 = 2'd2
  } seq_e;

  phase_e phase;
  phase_e prevState_q, prevState_d;
  seq_e   seq_q, seq_d;
  logic   justReset_q;
  logic   computeDone_q, computeDone_d;
  logic   isCompute, phaseStart, opFirst, opSecond;

  logic [WIDTH-1:0] x_q, x_d, dx_q, dx_d, u_q, u_d, a_q, a_d, y_q, y_d;
  logic [WIDTH-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, m4_q, m4_d;
  logic [WIDTH-1:0] m5_q, m5_d, yn_q, yn_d;
  logic [WIDTH-1:0] mulA, mulB, product, tripleIn, triple;

  assign phase     = phase_e'(bus.state);
  assign isCompute = (phase == PH_C1) || (phase == PH_C2) ||
                     (phase == PH_C3) || (phase == PH_C4);

  // Phase sequencer. A code seen on the cycle right after reset is treated as
  // already current, so a controller parked in a compute code does not
  // retrigger a phase just because reset cleared the previous-state register.
  always_comb begin
    seq_d         = SEQ_IDLE;
    computeDone_d = 1'b0;
    opFirst       = 1'b0;
    opSecond      = 1'b0;
    prevState_d   = phase;
    phaseStart    = isCompute && !justReset_q && (phase != prevState_q);
    if (phaseStart) begin
      opFirst = 1'b1;
      seq_d   = SEQ_CYC1;
    end else if (isCompute && (phase == prevState_q)) begin
      case (seq_q)
        SEQ_CYC1: begin
          opSecond      = 1'b1;
          computeDone_d = 1'b1;
          seq_d         = SEQ_CYC2;
        end
        default: seq_d = SEQ_IDLE;
      endcase
    end
  end

  // Operand steering for the single shared multiplier and the 3*v adder.
  always_comb begin
    mulA     = u_q;
    mulB     = dx_q;
    tripleIn = x_q;
    case (phase)
      PH_C2: begin
        mulA     = m2_q;
        mulB     = m1_q;
        tripleIn = y_q;
      end
      PH_C3: begin
        mulA = m4_q;
        mulB = dx_q;
      end
      default: ;
    endcase
  end

  assign product = mulA * mulB;
  assign triple  = (tripleIn << 1) + tripleIn;

  always_comb begin
    x_d  = x_q;
    dx_d = dx_q;
    u_d  = u_q;
    a_d  = a_q;
    y_d  = y_q;
    m1_d = m1_q;
    m2_d = m2_q;
    m3_d = m3_q;
    m4_d = m4_q;
    m5_d = m5_q;
    yn_d = yn_q;
    case (phase)
      PH_IDLE, PH_READ: begin
        if (bus.load_x) begin
          x_d = bus.data_in;
          y_d = '0;
        end
        if (bus.load_dx) dx_d = bus.data_in;
        if (bus.load_u)  u_d  = bus.data_in;
        if (bus.load_a)  a_d  = bus.data_in;
      end
      PH_C1: begin
        if (opFirst)       m1_d = product;
        else if (opSecond) m2_d = triple;
      end
      PH_C2: begin
        if (opFirst)       m3_d = product;
        else if (opSecond) m4_d = triple;
      end
      PH_C3: begin
        if (opFirst)       m5_d = product;
        else if (opSecond) yn_d = y_q + m1_q;
      end
      PH_C4: begin
        if (opSecond) begin
          u_d = u_q - m3_q - m5_q;
          y_d = yn_q;
          x_d = x_q + dx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prevState_q   <= PH_IDLE;
      seq_q         <= SEQ_IDLE;
      justReset_q   <= 1'b1;
      computeDone_q <= 1'b0;
      x_q  <= '0;
      dx_q <= '0;
      u_q  <= '0;
      a_q  <= '0;
      y_q  <= '0;
      m1_q <= '0;
      m2_q <= '0;
      m3_q <= '0;
      m4_q <= '0;
      m5_q <= '0;
      yn_q <= '0;
    end else begin
      prevState_q   <= prevState_d;
      seq_q         <= seq_d;
      justReset_q   <= 1'b0;
      computeDone_q <= computeDone_d;
      x_q  <= x_d;
      dx_q <= dx_d;
      u_q  <= u_d;
      a_q  <= a_d;
      y_q  <= y_d;
      m1_q <= m1_d;
      m2_q <= m2_d;
      m3_q <= m3_d;
      m4_q <= m4_d;
      m5_q <= m5_d;
      yn_q <= yn_d;
    end
  end

  assign bus.compute_done   = computeDone_q;
  assign bus.continue_while = $signed(x_q) < $signed(a_q);
  assign bus.x_out          = x_q;
  assign bus.y_out          = y_q;
  assign bus.u_out          = u_q;

endmodule

// File: tb/tb_diffeq_datapath.sv
// Directed bench for diffeq_datapath: vector tables for loads and full Euler
// loops, plus hand sequences for phase-hold, reset and abandoned phases.
module tb_diffeq_datapath;

  localparam int WIDTH = 16;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_READ = 3'b001;
  localparam logic [2:0] S_C1   = 3'b010;
  localparam logic [2:0] S_C2   = 3'b011;
  localparam logic [2:0] S_DONE = 3'b110;

  typedef struct {
    logic [2:0]  state;
    logic [3:0]  loads;
    logic [15:0] data;
    logic        cd;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] u;
    logic        cw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  diffeq_datapath_if #(.WIDTH(WIDTH)) bus ();

  diffeq_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads are packed {load_x, load_dx, load_u, load_a}.
  task automatic applyStimulus(input vec_t v);
    bus.state   = v.state;
    bus.load_x  = v.loads[3];
    bus.load_dx = v.loads[2];
    bus.load_u  = v.loads[1];
    bus.load_a  = v.loads[0];
    bus.data_in = v.data;
  endtask

  task automatic driveState(input logic [2:0] st);
    bus.state   = st;
    bus.load_x  = 1'b0;
    bus.load_dx = 1'b0;
    bus.load_u  = 1'b0;
    bus.load_a  = 1'b0;
    bus.data_in = '0;
  endtask

  task automatic checkOutput(input string name, input logic cd, input logic [15:0] ex,
                             input logic [15:0] ey, input logic [15:0] eu, input logic cw);
    checks++;
    if (bus.compute_done !== cd || bus.x_out !== ex || bus.y_out !== ey ||
        bus.u_out !== eu || bus.continue_while !== cw) begin
      errors++;
      $display("[TB] FAIL %s: got cd=%b x=%h y=%h u=%h cw=%b, expected cd=%b x=%h y=%h u=%h cw=%b",
               name, bus.compute_done, bus.x_out, bus.y_out, bus.u_out, bus.continue_while,
               cd, ex, ey, eu, cw);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void addVec(input logic [2:0] st, input logic [3:0] ld, input logic [15:0] d,
                                 input logic cd, input logic [15:0] ex, input logic [15:0] ey,
                                 input logic [15:0] eu, input logic cw);
    vec_t v;
    v.state = st;
    v.loads = ld;
    v.data  = d;
    v.cd    = cd;
    v.x     = ex;
    v.y     = ey;
    v.u     = eu;
    v.cw    = cw;
    vecs.push_back(v);
  endfunction

  // Two vectors per phase: the phase's compute_done shows after the second,
  // and the C4 commit is visible in that same observation.
  function automatic void addLoop(input logic [15:0] px, input logic [15:0] py,
                                  input logic [15:0] pu, input logic pcw,
                                  input logic [15:0] nx, input logic [15:0] ny,
                                  input logic [15:0] nu, input logic ncw,
                                  input logic [3:0] c2Loads, input logic [15:0] c2Data);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 2; c++) begin
        logic [2:0] st;
        logic       last;
        st   = 3'(p + 2);
        last = (p == 3) && (c == 1);
        addVec(st, (p == 1) ? c2Loads : 4'b0000, (p == 1) ? c2Data : 16'h0000,
               (c == 1), last ? nx : px, last ? ny : py, last ? nu : pu, last ? ncw : pcw);
      end
    end
  endfunction

  task automatic runTable(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("%s_vec%0d", tag, i), vecs[i].cd, vecs[i].x, vecs[i].y,
                  vecs[i].u, vecs[i].cw);
    end
    vecs.delete();
  endtask

  task automatic doReset();
    driveState(S_IDLE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int pos;

    $display("[TB] starting diffeq_datapath bench");
    driveState(S_IDLE);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset_state", 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;

    // One loop, x=0 dx=1 u=2 a=1, then loads ignored in DONE.
    addVec(S_IDLE, 4'b1000, 16'h0000, 0, 16'h0, 16'h0, 16'h0, 0);
    addVec(S_READ, 4'b0100, 16'h0001, 0, 16'h0, 16'h0, 16'h0, 0);
    addVec(S_READ, 4'b0010, 16'h0002, 0, 16'h0, 16'h0, 16'h2, 0);
    addVec(S_READ, 4'b0001, 16'h0001, 0, 16'h0, 16'h0, 16'h2, 1);
    addLoop(16'h0, 16'h0, 16'h2, 1, 16'h1, 16'h2, 16'h2, 0, 4'b0000, 16'h0);
    addVec(S_DONE, 4'b0000, 16'h0000, 0, 16'h1, 16'h2, 16'h2, 0);
    addVec(S_DONE, 4'b1000, 16'h0005, 0, 16'h1, 16'h2, 16'h2, 0);
    // Two loops, x=0 dx=1 u=1 a=2; load_x during C2 of loop 2 is ignored.
    addVec(S_IDLE, 4'b1000, 16'h0000, 0, 16'h0, 16'h0, 16'h2, 1);
    addVec(S_READ, 4'b0010, 16'h0001, 0, 16'h0, 16'h0, 16'h1, 1);
    addVec(S_READ, 4'b0001, 16'h0002, 0, 16'h0, 16'h0, 16'h1, 1);
    addLoop(16'h0, 16'h0, 16'h1, 1, 16'h1, 16'h1, 16'h1, 1, 4'b0000, 16'h0);
    addLoop(16'h1, 16'h1, 16'h1, 1, 16'h2, 16'h2, 16'hFFFB, 0, 4'b1000, 16'h0005);
    addVec(S_DONE, 4'b0000, 16'h0000, 0, 16'h2, 16'h2, 16'hFFFB, 0);
    runTable("loops");

    // C1 held for ten cycles: single pulse in the third cycle.
    driveState(S_IDLE);
    tick();
    driveState(S_C1);
    pulses = 0;
    pos    = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus.compute_done === 1'b1) begin
        pulses++;
        if (pos < 0) pos = i;
      end else if (bus.compute_done !== 1'b0) begin
        pulses += 100;
      end
      tick();
    end
    checkCount("hold_c1_pulses", pulses, 1);
    checkCount("hold_c1_position", pos, 2);

    // Wrap case: u=0x8000.
    doReset();
    addVec(S_IDLE, 4'b0010, 16'h8000, 0, 16'h0, 16'h0, 16'h8000, 0);
    addVec(S_READ, 4'b0100, 16'h0001, 0, 16'h0, 16'h0, 16'h8000, 0);
    addVec(S_READ, 4'b1000, 16'h0000, 0, 16'h0, 16'h0, 16'h8000, 0);
    addVec(S_READ, 4'b0001, 16'h0001, 0, 16'h0, 16'h0, 16'h8000, 1);
    addLoop(16'h0, 16'h0, 16'h8000, 1, 16'h1, 16'h8000, 16'h8000, 0, 4'b0000, 16'h0);
    runTable("wrap");

    // Reset asserted in C2 cycle 1 with nonzero registers.
    doReset();
    addVec(S_IDLE, 4'b1000, 16'h0003, 0, 16'h3, 16'h0, 16'h0, 0);
    addVec(S_READ, 4'b0010, 16'h0009, 0, 16'h3, 16'h0, 16'h9, 0);
    addVec(S_READ, 4'b0001, 16'h0007, 0, 16'h3, 16'h0, 16'h9, 1);
    runTable("preload");
    driveState(S_C2);
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_midphase", 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("rst_hold%0d", i), 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    end

    // C1 abandoned after one cycle; only the C2 phase completes.
    driveState(S_IDLE);
    tick();
    driveState(S_C1);
    tick();
    checkOutput("abandon0", 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    driveState(S_C2);
    tick();
    checkOutput("abandon1", 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);
    tick();
    checkOutput("abandon2", 1'b1, 16'h0, 16'h0, 16'h0, 1'b0);
    tick();
    checkOutput("abandon3", 1'b0, 16'h0, 16'h0, 16'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
